// File: rtl/ff_excite_seq.sv
// ff_excite_seq: target-state FIFO driving registered T/SR/JK excitation of an internal Q.
// Define FF_CHECK_EN to add the shadow T-flip-flop checker, the inj port and a live err_cnt.
module ff_excite_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_q,
  output logic             tgt_ready,
  output logic             t,
  output logic             s,
  output logic             r,
  output logic             j,
  output logic             k,
  output logic             q,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt
`ifdef FF_CHECK_EN
  ,
  input  logic             inj
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;
  logic mem [DEPTH];
  logic push, pop, g;
  assign push = tgt_valid && tgt_ready;
  assign pop = cnt != '0;
  assign g = mem[rp];
  assign busy = state != IDLE;
  assign cnt_n = (push && !pop) ? cnt + 1'b1 : (pop && !push) ? cnt - 1'b1 : cnt;
  always_comb begin
    state_n = state;
    state_n = pop ? RUN : (state == RUN) ? DRAIN : IDLE;
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= tgt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      tgt_ready <= 1'b1;
      {t, s, r, j, k, q} <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      tgt_ready <= cnt_n != FULL;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      t <= pop && (q ^ g);
      s <= pop && g && !q;
      r <= pop && q && !g;
      j <= pop && g && !q;
      k <= pop && q && !g;
      if (pop) q <= g;
    end
`ifdef FF_CHECK_EN
  // sq lags q by one cycle; after a mismatch it is resynced to the reference target
  logic exc_v, chk_v, sq, tgt_d, mis;
  assign mis = chk_v && (sq != tgt_d);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      exc_v <= 1'b0;
      chk_v <= 1'b0;
      sq <= 1'b0;
      tgt_d <= 1'b0;
      err_cnt <= '0;
    end else begin
      exc_v <= pop;
      chk_v <= exc_v;
      tgt_d <= q;
      sq <= (mis ? tgt_d : sq) ^ t ^ inj;
      if (mis && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_ff_excite_seq.sv
// tb_ff_excite_seq: scoreboard bench for ff_excite_seq; checker tests run when FF_CHECK_EN is defined.
module tb_ff_excite_seq;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, tgt_valid = 0, tgt_q = 0, inj = 0;
  logic tgt_ready, t, s, r, j, k, q, busy;
  logic [7:0] err_cnt;
  int compared = 0, mismatched = 0;
  logic [5:0] sb [$];
  logic mq = 0, out_q = 0, due = 0;
  always #5 clk = ~clk;
  ff_excite_seq #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_q(tgt_q), .tgt_ready(tgt_ready),
    .t(t), .s(s), .r(r), .j(j), .k(k), .q(q), .busy(busy), .err_cnt(err_cnt)
`ifdef FF_CHECK_EN
    , .inj(inj)
`endif
  );
`ifdef FF_CHECK_EN
  logic [1:0] err2;
  logic [7:0] u2;
  ff_excite_seq #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_q(tgt_q), .tgt_ready(u2[0]),
    .t(u2[1]), .s(u2[2]), .r(u2[3]), .j(u2[4]), .k(u2[5]), .q(u2[6]), .busy(u2[7]),
    .err_cnt(err2), .inj(1'b1)
  );
`endif

  // drive one cycle from a negedge; expected excitation is queued on acceptance and popped one edge later
  task automatic cycle(input logic v, input logic b);
    logic acc;
    logic [5:0] e;
    tgt_valid = v;
    tgt_q = b;
    acc = v && tgt_ready;
    if (acc) begin
      sb.push_back({mq ^ b, b & ~mq, mq & ~b, b & ~mq, mq & ~b, b});
      mq = b;
    end
    @(negedge clk);
    e = {5'b0, out_q};
    if (due && sb.size() > 0) e = sb.pop_front();
    compared++;
    if ({t, s, r, j, k, q} !== e) begin
      mismatched++;
      $display("FAIL %s: tsrjkq got %b expected %b", due ? "sb_target" : "sb_idle", {t, s, r, j, k, q}, e);
    end
    out_q = e[0];
    due = acc;
  endtask

  task automatic clear_model();
    sb.delete();
    mq = 0;
    out_q = 0;
    due = 0;
  endtask

  task automatic apply_reset();
    tgt_valid = 0;
    #2 rst = 1;
    clear_model();
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    compared++;
    if (tgt_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b expected 1", tgt_ready); end
    compared++;
    if ({t, s, r, j, k, q} !== 6'b0) begin mismatched++; $display("FAIL rst_outputs: got %b expected 000000", {t, s, r, j, k, q}); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b expected 0", busy); end
    compared++;
    if (err_cnt !== 8'd0) begin mismatched++; $display("FAIL rst_err: got %0d expected 0", err_cnt); end
    #2 rst = 0;
    @(negedge clk);
  endtask

  task automatic test_sequence();
    logic [3:0] tg = 4'b1001, et = 4'b1101, eq = 4'b1001, es = 4'b1001, er = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      cycle(i < 4, tg[(3 - i) & 3] && i < 4);
      if (i >= 1 && i <= 4) begin
        compared++;
        if ({t, q, s, r} !== {et[4 - i], eq[4 - i], es[4 - i], er[4 - i]}) begin
          mismatched++;
          $display("FAIL seq[%0d]: tqsr got %b expected %b", i - 1, {t, q, s, r}, {et[4 - i], eq[4 - i], es[4 - i], er[4 - i]});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (tgt_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, tgt_ready); end
      cycle(1'b1, 1'($urandom_range(0, 1)));
    end
    repeat (3) cycle(1'b0, 1'b0);
  endtask

  task automatic test_busy();
    logic [5:0] eb = 6'b011100;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL busy_pre: got %b expected 0", busy); end
    for (int i = 0; i < 6; i++) begin
      cycle(i < 2, 1'b1);
      compared++;
      if (busy !== eb[5 - i]) begin mismatched++; $display("FAIL busy[%0d]: got %b expected %b", i, busy, eb[5 - i]); end
      if (i == 2) begin
        compared++;
        if (t !== 1'b0) begin mismatched++; $display("FAIL busy_t2: got %b expected 0", t); end
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    tgt_valid = 0;
    #2 rst = 1;
    #1;
    compared++;
    if ({t, s, r, j, k, q, busy} !== 7'b0) begin
      mismatched++;
      $display("FAIL midrst_async: tsrjkq,busy got %b expected 0000000", {t, s, r, j, k, q, busy});
    end
    compared++;
    if (tgt_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_ready: got %b expected 1", tgt_ready); end
    clear_model();
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    repeat (3) cycle(1'b0, 1'b0);
    compared++;
    if (tgt_ready !== 1'b1) begin mismatched++; $display("FAIL postrst_ready: got %b expected 1", tgt_ready); end
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL postrst_busy: got %b expected 1", busy); end
    repeat (3) cycle(1'b0, 1'b0);
  endtask

  task automatic test_err_quiet();
    compared++;
    if (err_cnt !== 8'd0) begin mismatched++; $display("FAIL err_quiet: got %0d expected 0", err_cnt); end
  endtask

`ifdef FF_CHECK_EN
  task automatic test_checker();
    apply_reset();
    compared++;
    if (err_cnt !== 8'd0) begin mismatched++; $display("FAIL chk_pre: got %0d expected 0", err_cnt); end
    for (int i = 0; i < 5; i++) begin
      inj = (i == 2);
      cycle(1'b1, 1'($urandom_range(0, 1)));
    end
    inj = 0;
    repeat (6) cycle(1'b0, 1'b0);
    compared++;
    if (err_cnt !== 8'd1) begin mismatched++; $display("FAIL chk_err: got %0d expected 1", err_cnt); end
    repeat (4) cycle(1'b0, 1'b0);
    compared++;
    if (err_cnt !== 8'd1) begin mismatched++; $display("FAIL chk_stable: got %0d expected 1", err_cnt); end
    compared++;
    if (err2 !== 2'd3) begin mismatched++; $display("FAIL chk_sat: got %0d expected 3", err2); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    test_err_quiet();
`ifdef FF_CHECK_EN
    test_checker();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
